// File: rtl/nested_loop_counter.sv
// nested_loop_counter: chain of LEVELS wrap-around counters used as nested
// loop indices (level 0 innermost). A start/busy/last handshake frames one
// full sweep of the index space.
// Optional feature (macro NESTED_LOOP_COUNTER_REPEAT_EN): adds the input
// repeat_sweep. When it is high at the completing advance, the sweep restarts
// in place instead of returning to IDLE. The name repeat_sweep is used because
// "repeat" is a reserved word.
module nested_loop_counter #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    advance,
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
  input  logic                    repeat_sweep,
`endif
  input  logic [LEVELS*WIDTH-1:0] max_flat,
  output logic [LEVELS*WIDTH-1:0] count_flat,
  output logic [LEVELS-1:0]       wrap,
  output logic                    busy,
  output logic                    last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                       state_r, state_s;
  logic [LEVELS-1:0][WIDTH-1:0] count_r, count_s;
  logic [LEVELS-1:0][WIDTH-1:0] max_r, max_s;
  logic [LEVELS-1:0]            wrap_r, wrap_s;
  logic                         busy_r, busy_s;
  logic                         last_r, last_s;
  logic                         carry_s;
  logic                         rep_s;

`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
  assign rep_s = repeat_sweep;
`else
  assign rep_s = 1'b0;
`endif

  // Next-state logic: stop beats start beats advance. The carry ripples from
  // level 0 upward, and it survives past the top level only when the sweep completes.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    max_s   = max_r;
    wrap_s  = '0;
    last_s  = 1'b0;
    carry_s = 1'b0;
    case (state_r)
      IDLE: begin
        count_s = '0;
        if (start && !stop) begin
          max_s   = max_flat;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          count_s = '0;
          state_s = IDLE;
        end else if (advance) begin
          carry_s = 1'b1;
          for (int i = 0; i < LEVELS; i++) begin
            if (carry_s) begin
              if (count_r[i] == max_r[i]) begin
                count_s[i] = '0;
                wrap_s[i]  = 1'b1;
              end else begin
                count_s[i] = count_r[i] + WIDTH'(1);
                carry_s    = 1'b0;
              end
            end else begin
              count_s[i] = count_r[i];
            end
          end
          if (carry_s) begin
            last_s  = 1'b1;
            state_s = rep_s ? RUN : IDLE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        count_s = '0;
      end
    endcase
    busy_s = (state_s == RUN);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      count_r <= '0;
      max_r   <= '0;
      wrap_r  <= '0;
      busy_r  <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      max_r   <= max_s;
      wrap_r  <= wrap_s;
      busy_r  <= busy_s;
      last_r  <= last_s;
    end
  end

  assign count_flat = count_r;
  assign wrap       = wrap_r;
  assign busy       = busy_r;
  assign last       = last_r;

endmodule

// File: tb/tb_nested_loop_counter.sv
// tb_nested_loop_counter: scoreboard bench for nested_loop_counter
// (WIDTH=4, LEVELS=2). The reference model tracks one flat sweep position and
// derives the per-level indices and wrap pulses from it with mixed-radix
// arithmetic. Define NESTED_LOOP_COUNTER_REPEAT_EN to exercise repeat_sweep.
`timescale 1ns/1ps
module tb_nested_loop_counter;
  localparam int W = 4;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         advance = 1'b0;
  logic         rep = 1'b0;
  logic [L*W-1:0] max_flat = '0;
  logic [L*W-1:0] count_flat;
  logic [L-1:0] wrap;
  logic         busy;
  logic         last;

  nested_loop_counter #(.WIDTH(W), .LEVELS(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .advance    (advance),
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
    .repeat_sweep (rep),
`endif
    .max_flat   (max_flat),
    .count_flat (count_flat),
    .wrap       (wrap),
    .busy       (busy),
    .last       (last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L*W-1:0] count;
    logic [L-1:0]   wrap;
    logic           busy;
    logic           last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total_checks = 0;
  int   passed = 0;

  // Reference model: running flag, latched maxima, and the flat position in the sweep
  bit m_run = 1'b0;
  int m_max[L];
  int m_p = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Product of (max_j + 1) over levels below lvl
  function automatic int radix_below(input int lvl);
    int p = 1;
    for (int j = 0; j < lvl; j++) p = p * (m_max[j] + 1);
    return p;
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit adv, input bit rp,
                            input logic [L*W-1:0] mx, output exp_t e);
    e = '0;
    if (!m_run) begin
      if (st && !sp) begin
        m_run = 1'b1;
        m_p = 0;
        for (int i = 0; i < L; i++) m_max[i] = int'(mx[i*W +: W]);
      end
    end else if (sp) begin
      m_run = 1'b0;
      m_p = 0;
    end else if (adv) begin
      m_p++;
      for (int i = 0; i < L; i++)
        if (m_p % radix_below(i + 1) == 0) e.wrap[i] = 1'b1;
      if (m_p == radix_below(L)) begin
        m_p = 0;
        e.last = 1'b1;
        if (!rp) m_run = 1'b0;
      end
    end
    for (int i = 0; i < L; i++)
      e.count[i*W +: W] = W'((m_p / radix_below(i)) % (m_max[i] + 1));
    e.busy = m_run;
  endtask

  // Drive at the falling edge and queue the expectation for the next rising edge
  task automatic step(input bit st, input bit sp, input bit adv, input bit rp,
                      input logic [L*W-1:0] mx);
    exp_t e;
    start = st; stop = sp; advance = adv; rep = rp; max_flat = mx;
    model_step(st, sp, adv, rp, mx, e);
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare registered outputs just after each rising edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("count", count_flat, mon_e.count);
      chk("wrap",  wrap,       mon_e.wrap);
      chk("busy",  busy,       mon_e.busy);
      chk("last",  last,       mon_e.last);
    end
  end

  logic [L*W-1:0] seq2 [6];
  bit rp_r;

  initial begin
    seq2[0] = 8'h01; seq2[1] = 8'h10; seq2[2] = 8'h11;
    seq2[3] = 8'h20; seq2[4] = 8'h21; seq2[5] = 8'h00;
    for (int i = 0; i < L; i++) m_max[i] = 0;

    // Reset values
    #3;
    chk("rst_count", count_flat, 0);
    chk("rst_wrap",  wrap, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_last",  last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: asynchronous reset in the middle of RUN, at count (1,1)
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    chk("t1_pre_count", count_flat, 8'h11);
    chk("t1_pre_busy",  busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_count", count_flat, 0);
    chk("t1_async_busy",  busy, 0);
    chk("t1_async_last",  last, 0);
    m_run = 1'b0; m_p = 0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Test 2: max {L1=2, L0=1}, six advances
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h21);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h21);
      chk("t2_seq", count_flat, seq2[k]);
      chk("t2_wrap0", wrap[0], (k % 2 == 1) ? 1 : 0);
      chk("t2_last", last, (k == 5) ? 1 : 0);
    end
    chk("t2_busy_end", busy, 0);

    // Test 3: all maxima zero
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("t3_last", last, 1);
    chk("t3_wrap", wrap, 2'b11);
    chk("t3_busy", busy, 0);

    // Test 4: stop with advance; max_flat changed mid-RUN is ignored
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    chk("t4_latched", count_flat, 8'h11);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_last", last, 0);

    // Test 5: start+stop in IDLE, advance in IDLE, gaps in RUN
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
    chk("t5_startstop", busy, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h22);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);

    // Random phase
    for (int k = 0; k < 800; k++) begin
      logic [L*W-1:0] mx;
      for (int i = 0; i < L; i++) mx[i*W +: W] = W'($urandom_range(0, 3));
      rp_r = 1'b0;
`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
      rp_r = ($urandom % 2) == 0;
`endif
      step(($urandom % 8) == 0, ($urandom % 24) == 0, ($urandom % 4) != 0, rp_r, mx);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

`ifdef NESTED_LOOP_COUNTER_REPEAT_EN
    // Test 6: repeat keeps the sweep running across completion
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, (k == 7) ? 1'b0 : 1'b1, 8'h11);
      if (k == 3) begin
        chk("t6_last4", last, 1);
        chk("t6_busy4", busy, 1);
      end
    end
    chk("t6_last8", last, 1);
    chk("t6_busy8", busy, 0);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end
endmodule
